// File: rtl/haze_acq_ctrl.sv
// haze_acq_ctrl: sequences a settle/acquire/flush window of laser samples into haze_generate
module haze_acq_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int CNT_WIDTH    = 16,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [CNT_WIDTH-1:0]  settle_len_i,
  input  logic [CNT_WIDTH-1:0]  acq_len_i,
  input  logic                  laser_vld_i,
  input  logic [DATA_WIDTH-1:0] laser_data_i,
  output logic                  haze_rst_o,
  output logic                  haze_vld_o,
  output logic [DATA_WIDTH-1:0] haze_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  sample_cnt_o,
  output logic                  overrun_o
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, ACQ, FLUSH, DONE} state_t;
  state_t r_state, w_state;
  logic [CNT_WIDTH-1:0] r_settle_len, r_acq_len, r_settle_cnt, r_cnt;
  logic [FW-1:0] r_flush_cnt;
  logic [DATA_WIDTH-1:0] r_haze_data;
  logic r_haze_rst, r_haze_vld, r_busy, r_done, r_overrun;
  logic w_abort, w_start, w_fwd, w_drop;
  always_comb begin
    w_abort = abort_i && r_state != IDLE;
    w_start = start_i && r_state == IDLE && acq_len_i != '0;
    w_fwd   = !w_abort && r_state == ACQ && laser_vld_i;
    w_drop  = !w_abort && r_state == SETTLE && laser_vld_i;
    w_state = r_state;
    if (w_abort)
      w_state = IDLE;
    else
      case (r_state)
        IDLE:    w_state = w_start ? CLEAR : IDLE;
        CLEAR:   w_state = r_settle_len == '0 ? ACQ : SETTLE;
        SETTLE:  w_state = (w_drop && r_settle_cnt + CNT_WIDTH'(1) == r_settle_len) ? ACQ : SETTLE;
        ACQ:     w_state = (w_fwd && r_cnt + CNT_WIDTH'(1) == r_acq_len) ? FLUSH : ACQ;
        // FLUSH is entered on the edge of the last forwarded sample, so it spans FLUSH_CYCLES+1 cycles
        FLUSH:   w_state = r_flush_cnt == FW'(FLUSH_CYCLES) ? DONE : FLUSH;
        DONE:    w_state = IDLE;
        default: w_state = IDLE;
      endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state      <= IDLE;
      r_settle_len <= '0;
      r_acq_len    <= '0;
      r_settle_cnt <= '0;
      r_cnt        <= '0;
      r_flush_cnt  <= '0;
      r_haze_data  <= '0;
      r_haze_rst   <= 1'b1;
      r_haze_vld   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_haze_rst  <= w_state == CLEAR;
      r_busy      <= w_state != IDLE;
      r_done      <= w_state == DONE;
      r_haze_vld  <= w_fwd;
      r_flush_cnt <= r_state == FLUSH ? r_flush_cnt + FW'(1) : '0;
      if (w_fwd) begin
        r_haze_data <= laser_data_i;
        r_cnt       <= r_cnt + CNT_WIDTH'(1);
      end
      if (w_drop)
        r_settle_cnt <= r_settle_cnt + CNT_WIDTH'(1);
      if (w_start) begin
        r_settle_len <= settle_len_i;
        r_acq_len    <= acq_len_i;
        r_settle_cnt <= '0;
        r_cnt        <= '0;
        r_overrun    <= 1'b0;
      end else if (start_i && r_state != IDLE && !w_abort)
        r_overrun <= 1'b1;
    end
  end
  assign haze_rst_o   = r_haze_rst;
  assign haze_vld_o   = r_haze_vld;
  assign haze_data_o  = r_haze_data;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign sample_cnt_o = r_cnt;
  assign overrun_o    = r_overrun;
endmodule

// File: tb/tb_haze_acq_ctrl.sv
// tb_haze_acq_ctrl: directed self-checking bench for haze_acq_ctrl
module tb_haze_acq_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_n_i, start_i, abort_i, laser_vld_i;
  logic [15:0] settle_len_i, acq_len_i;
  logic [31:0] laser_data_i;
  logic        haze_rst_o, haze_vld_o, busy_o, done_o, overrun_o;
  logic [31:0] haze_data_o;
  logic [15:0] sample_cnt_o;
  int tests = 0;
  int fails = 0;
  logic [31:0] d_prev;
  haze_acq_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
    .settle_len_i(settle_len_i), .acq_len_i(acq_len_i),
    .laser_vld_i(laser_vld_i), .laser_data_i(laser_data_i),
    .haze_rst_o(haze_rst_o), .haze_vld_o(haze_vld_o), .haze_data_o(haze_data_o),
    .busy_o(busy_o), .done_o(done_o), .sample_cnt_o(sample_cnt_o), .overrun_o(overrun_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rst"}, 32'(haze_rst_o), 1);
    chk({tag, "_vld"}, 32'(haze_vld_o), 0);
    chk({tag, "_data"}, haze_data_o, 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_cnt"}, 32'(sample_cnt_o), 0);
    chk({tag, "_ovr"}, 32'(overrun_o), 0);
  endtask
  initial begin
    rst_n_i = 0; start_i = 0; abort_i = 0; laser_vld_i = 0;
    settle_len_i = 0; acq_len_i = 0; laser_data_i = 0;
    tick;
    chk_reset_vals("por");
    rst_n_i = 1;
    tick;
    chk("por_release_rst", 32'(haze_rst_o), 0);
    // basic window: settle 3, acquire 5, alternating valid
    settle_len_i = 3; acq_len_i = 5; start_i = 1;
    tick;
    chk("b_clear_rst", 32'(haze_rst_o), 1);
    chk("b_clear_busy", 32'(busy_o), 1);
    start_i = 0;
    tick;
    chk("b_settle_rst", 32'(haze_rst_o), 0);
    for (int i = 0; i <= 14; i++) begin
      laser_vld_i = (i % 2 == 0);
      laser_data_i = $urandom;
      d_prev = laser_data_i;
      tick;
      chk($sformatf("b_vld%0d", i), 32'(haze_vld_o), 32'(i >= 6 && i % 2 == 0));
      if (i >= 6 && i % 2 == 0) chk($sformatf("b_data%0d", i), haze_data_o, d_prev);
    end
    chk("b_cnt", 32'(sample_cnt_o), 5);
    for (int k = 1; k <= 9; k++) begin
      laser_vld_i = (k % 2 == 1);
      laser_data_i = $urandom;
      tick;
      chk($sformatf("b_fl_vld%0d", k), 32'(haze_vld_o), 0);
      chk($sformatf("b_done%0d", k), 32'(done_o), 32'(k == 9));
    end
    chk("b_done_busy", 32'(busy_o), 1);
    laser_vld_i = 0;
    tick;
    chk("b_idle_done", 32'(done_o), 0);
    chk("b_idle_busy", 32'(busy_o), 0);
    chk("b_idle_cnt", 32'(sample_cnt_o), 5);
    // zero settle: constant valid, exactly 2 forwarded back to back
    settle_len_i = 0; acq_len_i = 2; start_i = 1; laser_vld_i = 1; laser_data_i = 32'h1111_0000;
    tick;
    chk("z_clear_rst", 32'(haze_rst_o), 1);
    start_i = 0; laser_data_i = 32'h1111_0001;
    tick;
    chk("z_clear_vld", 32'(haze_vld_o), 0);
    laser_data_i = 32'h1111_0002;
    tick;
    chk("z_vld1", 32'(haze_vld_o), 1);
    chk("z_data1", haze_data_o, 32'h1111_0002);
    laser_data_i = 32'h1111_0003;
    tick;
    chk("z_vld2", 32'(haze_vld_o), 1);
    chk("z_data2", haze_data_o, 32'h1111_0003);
    for (int k = 1; k <= 9; k++) begin
      laser_data_i = 32'h2222_0000 + 32'(k);
      tick;
      chk($sformatf("z_fl_vld%0d", k), 32'(haze_vld_o), 0);
      chk($sformatf("z_done%0d", k), 32'(done_o), 32'(k == 9));
    end
    chk("z_cnt", 32'(sample_cnt_o), 2);
    chk("z_data_hold", haze_data_o, 32'h1111_0003);
    tick;
    // abort after the 4th forwarded sample of 10
    settle_len_i = 0; acq_len_i = 10; start_i = 1; laser_vld_i = 0;
    tick;
    start_i = 0; laser_vld_i = 1;
    tick;
    for (int k = 1; k <= 4; k++) begin
      laser_data_i = 32'h3300_0000 + 32'(k);
      tick;
      chk($sformatf("a_vld%0d", k), 32'(haze_vld_o), 1);
    end
    chk("a_cnt4", 32'(sample_cnt_o), 4);
    abort_i = 1;
    tick;
    abort_i = 0;
    chk("a_busy", 32'(busy_o), 0);
    chk("a_vld", 32'(haze_vld_o), 0);
    chk("a_rst", 32'(haze_rst_o), 0);
    chk("a_cnt", 32'(sample_cnt_o), 4);
    for (int k = 1; k <= 3; k++) begin
      tick;
      chk($sformatf("a_post_vld%0d", k), 32'(haze_vld_o), 0);
      chk($sformatf("a_post_done%0d", k), 32'(done_o), 0);
    end
    // overrun: start pulsed during SETTLE
    laser_vld_i = 0; settle_len_i = 2; acq_len_i = 1; start_i = 1;
    tick;
    chk("o_clear_ovr", 32'(overrun_o), 0);
    start_i = 0;
    tick;
    start_i = 1;
    tick;
    start_i = 0;
    chk("o_ovr_set", 32'(overrun_o), 1);
    chk("o_busy", 32'(busy_o), 1);
    chk("o_no_rst", 32'(haze_rst_o), 0);
    laser_vld_i = 1;
    tick;
    tick;
    chk("o_settle_vld", 32'(haze_vld_o), 0);
    laser_data_i = 32'h4444_4444;
    tick;
    chk("o_vld", 32'(haze_vld_o), 1);
    chk("o_data", haze_data_o, 32'h4444_4444);
    laser_vld_i = 0;
    for (int k = 1; k <= 9; k++) begin
      tick;
      chk($sformatf("o_done%0d", k), 32'(done_o), 32'(k == 9));
    end
    chk("o_ovr_at_done", 32'(overrun_o), 1);
    chk("o_cnt", 32'(sample_cnt_o), 1);
    tick;
    chk("o_ovr_idle", 32'(overrun_o), 1);
    // illegal zero length start
    acq_len_i = 0; start_i = 1;
    tick;
    start_i = 0;
    chk("i_busy", 32'(busy_o), 0);
    chk("i_rst", 32'(haze_rst_o), 0);
    chk("i_done", 32'(done_o), 0);
    chk("i_ovr", 32'(overrun_o), 1);
    tick;
    chk("i_busy2", 32'(busy_o), 0);
    // accepted start clears overrun, then reset mid-ACQ
    settle_len_i = 0; acq_len_i = 3; start_i = 1;
    tick;
    chk("r_ovr_clr", 32'(overrun_o), 0);
    chk("r_cnt_clr", 32'(sample_cnt_o), 0);
    chk("r_busy", 32'(busy_o), 1);
    start_i = 0; laser_vld_i = 1; laser_data_i = 32'h5555_0001;
    tick;
    tick;
    chk("r_vld", 32'(haze_vld_o), 1);
    chk("r_cnt1", 32'(sample_cnt_o), 1);
    rst_n_i = 0;
    tick;
    chk_reset_vals("mid");
    rst_n_i = 1; laser_vld_i = 0;
    tick;
    chk("mid_release_rst", 32'(haze_rst_o), 0);
    chk("mid_release_busy", 32'(busy_o), 0);
    settle_len_i = 1; acq_len_i = 1; start_i = 1;
    tick;
    chk("f_busy", 32'(busy_o), 1);
    chk("f_rst", 32'(haze_rst_o), 1);
    start_i = 0;
    tick;
    chk("f_rst_off", 32'(haze_rst_o), 0);
    laser_vld_i = 1; laser_data_i = 32'h6666_0001;
    tick;
    chk("f_settle_vld", 32'(haze_vld_o), 0);
    laser_data_i = 32'h6666_0002;
    tick;
    chk("f_vld", 32'(haze_vld_o), 1);
    chk("f_data", haze_data_o, 32'h6666_0002);
    laser_vld_i = 0;
    for (int k = 1; k <= 9; k++) begin
      tick;
      chk($sformatf("f_done%0d", k), 32'(done_o), 32'(k == 9));
    end
    chk("f_cnt", 32'(sample_cnt_o), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
